// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register pending bits.
//
// Decode reads operands (rsel/rdat/rrdy) and reserves destination registers
// (resv_en/resv_sel). Writeback writes results (wen/wsel/wdat), which also
// clears the pending bit. Register 0 is hardwired to zero and never pending.
//
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   wen/wsel/wdat     NUM_WR write ports, port i at [i*AW +: AW] / [i*DATA_W +: DATA_W]
//   rsel/rdat/rrdy    NUM_RD combinational read ports; rrdy=1 when not pending
//                     or being written this cycle
//   resv_en/resv_sel  reservation request (marks register pending)
//   resv_stall        reservation refused: target already pending, no write to it
//   pend_cnt          registered count of pending registers
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// the read ports. Without it rdat returns the stored (possibly stale) value.

module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*AW-1:0]     wsel,
  input  logic [NUM_WR*DATA_W-1:0] wdat,
  input  logic [NUM_RD*AW-1:0]     rsel,
  output logic [NUM_RD*DATA_W-1:0] rdat,
  output logic [NUM_RD-1:0]        rrdy,
  input  logic                     resv_en,
  input  logic [AW-1:0]            resv_sel,
  output logic                     resv_stall,
  output logic [AW:0]              pend_cnt
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wmask;     // registers written this cycle (r0 excluded)
  logic [NUM_REGS-1:0] pend_nxt;
  logic                set_acc;   // accepted, non-trivial reservation
  logic                inc;
  logic [AW:0]         dec;
  logic [AW:0]         cnt_nxt;

  // Write target mask
  always_comb begin
    wmask = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wen[j]) wmask[wsel[j*AW +: AW]] = 1'b1;
    end
    wmask[0] = 1'b0;
  end

  // Reservation handshake
  always_comb begin
    resv_stall = resv_en && (resv_sel != '0) && pending[resv_sel] && !wmask[resv_sel];
    set_acc    = resv_en && (resv_sel != '0) && !resv_stall;
  end

  // Next pending state and counter. The counter only moves by registers whose
  // pending bit actually changes: a set on an already-pending register that is
  // written the same cycle leaves the count unchanged.
  always_comb begin
    pend_nxt = pending & ~wmask;
    if (set_acc) pend_nxt[resv_sel] = 1'b1;
    pend_nxt[0] = 1'b0;

    inc = set_acc && !pending[resv_sel];
    dec = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (pending[r] && wmask[r] && !(set_acc && (resv_sel == AW'(r))))
        dec = dec + 1'b1;
    end
    cnt_nxt = pend_cnt + (AW+1)'(inc) - dec;
  end

  // State update; ascending port order makes the highest-index writer win.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wen[j] && (wsel[j*AW +: AW] != '0))
          mem[wsel[j*AW +: AW]] <= wdat[j*DATA_W +: DATA_W];
      end
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Combinational read ports
  always_comb begin
    logic [AW-1:0] rs;
    rdat = '0;
    rrdy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rs = rsel[i*AW +: AW];
      if (rs == '0) begin
        rdat[i*DATA_W +: DATA_W] = '0;
        rrdy[i]                  = 1'b1;
      end else begin
        rdat[i*DATA_W +: DATA_W] = mem[rs];
        rrdy[i]                  = !pending[rs] || wmask[rs];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wen[j] && (wsel[j*AW +: AW] == rs))
            rdat[i*DATA_W +: DATA_W] = wdat[j*DATA_W +: DATA_W];
        end
`else
`endif
      end
    end
  end

endmodule
